// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC engine and its request arbiter.
package cordic_pkg;

    localparam int CORDIC_W = 14;

    // Operation modes understood by the CORDIC engine; anything above MODE_MAX is illegal.
    localparam logic [3:0] MODE_ROT = 4'd0;
    localparam logic [3:0] MODE_MUL = 4'd1;
    localparam logic [3:0] MODE_DIV = 4'd2;
    localparam logic [3:0] MODE_MAX = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: the first requester after `ptr` (wrapping) wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int IW = $clog2(N);

    int cand;

    // Scan from the farthest offset down to ptr+1 so the nearest requester is the last hit and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that skips an
        // assignment in combinational logic would otherwise infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(ptr) + off) % N;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC engine among NREQ clients: round-robin grant, operand hold,
// start/finish handshake with a watchdog, and an ID-tagged response channel.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = CORDIC_W,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [4*NREQ-1:0]        req_mode,
    input  logic [W*NREQ-1:0]        req_x,
    input  logic [W*NREQ-1:0]        req_y,
    input  logic [W*NREQ-1:0]        req_z,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_err,
    output logic [W-1:0]             rsp_x,
    output logic [W-1:0]             rsp_y,
    output logic [W-1:0]             rsp_z,
    output logic                     cdc_start,
    output logic [3:0]               cdc_mode,
    output logic [W-1:0]             cdc_x,
    output logic [W-1:0]             cdc_y,
    output logic [W-1:0]             cdc_z,
    input  logic [W-1:0]             cdc_x_out,
    input  logic [W-1:0]             cdc_y_out,
    input  logic [W-1:0]             cdc_z_out,
    input  logic                     cdc_finish,
    output logic                     busy
);

    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 2);

    arb_state_t     state, state_nxt;
    logic [IW-1:0]  rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;
    logic [3:0]     sel_mode;
    logic [W-1:0]   sel_x, sel_y, sel_z;
    logic           accept, mode_bad;
    logic [WDW-1:0] wd, wd_inc;
    logic           timeout_hit;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_mode = req_mode[int'(gnt_idx)*4 +: 4];
    assign sel_x    = req_x[int'(gnt_idx)*W +: W];
    assign sel_y    = req_y[int'(gnt_idx)*W +: W];
    assign sel_z    = req_z[int'(gnt_idx)*W +: W];
    assign accept   = (state == ST_IDLE) && gnt_any;
    assign mode_bad = sel_mode > MODE_MAX;

    // wd_inc counts WAIT cycles including the current one, so the error response
    // lands TIMEOUT+1 cycles after the start pulse.
    assign wd_inc      = wd + 1'b1;
    assign timeout_hit = (wd_inc == WDW'(TIMEOUT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        cdc_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Gated by rst so no accept is advertised while the block is held in reset.
                if (!rst) req_ready = gnt;
                if (gnt_any) state_nxt = mode_bad ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                cdc_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cdc_finish || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand hold, pointer, watchdog and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the hold registers drive module outputs directly, so they are
            // reset like any other state rather than left undefined.
            cdc_mode <= '0;
            cdc_x    <= '0;
            cdc_y    <= '0;
            cdc_z    <= '0;
            rr_ptr   <= IW'(NREQ - 1);
            wd       <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
            rsp_x    <= '0;
            rsp_y    <= '0;
            rsp_z    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cdc_mode <= sel_mode;
                        cdc_x    <= sel_x;
                        cdc_y    <= sel_y;
                        cdc_z    <= sel_z;
                        rr_ptr   <= gnt_idx;
                        rsp_id   <= gnt_idx;
                        if (mode_bad) begin
                            rsp_err <= 1'b1;
                            rsp_x   <= '0;
                            rsp_y   <= '0;
                            rsp_z   <= '0;
                        end
                    end
                end
                ST_ISSUE: wd <= '0;
                ST_WAIT: begin
                    wd <= wd_inc;
                    if (cdc_finish) begin
                        rsp_err <= 1'b0;
                        rsp_x   <= cdc_x_out;
                        rsp_y   <= cdc_y_out;
                        rsp_z   <= cdc_z_out;
                    end else if (timeout_hit) begin
                        rsp_err <= 1'b1;
                        rsp_x   <= '0;
                        rsp_y   <= '0;
                        rsp_z   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency CORDIC stub.
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = CORDIC_W;
    localparam int TIMEOUT = 63;

    logic              clk, rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [4*NREQ-1:0] req_mode;
    logic [W*NREQ-1:0] req_x, req_y, req_z;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_x, rsp_y, rsp_z;
    logic              cdc_start, cdc_finish, busy;
    logic [3:0]        cdc_mode;
    logic [W-1:0]      cdc_x, cdc_y, cdc_z;
    logic [W-1:0]      cdc_x_out, cdc_y_out, cdc_z_out;

    int n_vec = 0;
    int n_err = 0;

    cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .cdc_start(cdc_start), .cdc_mode(cdc_mode),
        .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_z(cdc_z),
        .cdc_x_out(cdc_x_out), .cdc_y_out(cdc_y_out), .cdc_z_out(cdc_z_out),
        .cdc_finish(cdc_finish), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CORDIC stub: finish pulses stub_lat cycles after the start pulse.
    logic stub_en = 1'b1;
    logic stub_fin;
    logic fin_force = 1'b0;
    int   stub_lat = 5;
    int   stub_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt <= 0;
            stub_fin <= 1'b0;
        end else if (cdc_start && stub_en) begin
            stub_cnt <= stub_lat - 1;
            stub_fin <= 1'b0;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            stub_fin <= (stub_cnt == 1);
        end else begin
            stub_fin <= 1'b0;
        end
    end
    assign cdc_finish = stub_fin | fin_force;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] m, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] z);
        req_mode[k*4 +: 4] = m;
        req_x[k*W +: W]    = x;
        req_y[k*W +: W]    = y;
        req_z[k*W +: W]    = z;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_mode = '0; req_x = '0; req_y = '0; req_z = '0;
        cdc_x_out = 14'h0400; cdc_y_out = 14'h0100; cdc_z_out = 14'h0000;
        step(); step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
        n_vec++; if (cdc_start !== 1'b0) begin n_err++; $display("FAIL reset_cdc_start got %0h want 0", cdc_start); end
        n_vec++; if ({cdc_mode, cdc_x, cdc_y, cdc_z} !== '0) begin n_err++; $display("FAIL reset_hold got %h want 0", {cdc_mode, cdc_x, cdc_y, cdc_z}); end
        n_vec++; if ({rsp_id, rsp_err, rsp_x, rsp_y, rsp_z} !== '0) begin n_err++; $display("FAIL reset_rsp got %h want 0", {rsp_id, rsp_err, rsp_x, rsp_y, rsp_z}); end
        req_valid = 4'hF; #1;
        n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_req(0, 4'd1, 14'h0400, 14'h0000, 14'h1000);
        req_valid = 4'b0001; #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n_vec++; if (cdc_start !== 1'b1) begin n_err++; $display("FAIL single_start got %0h want 1", cdc_start); end
        n_vec++; if ({cdc_mode, cdc_x, cdc_z} !== {4'd1, 14'h0400, 14'h1000}) begin n_err++; $display("FAIL single_hold got %h want %h", {cdc_mode, cdc_x, cdc_z}, {4'd1, 14'h0400, 14'h1000}); end
        begin
            int quiet_bad = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (cdc_start !== 1'b0 || rsp_valid !== 1'b0) quiet_bad++;
            end
            n_vec++; if (quiet_bad != 0) begin n_err++; $display("FAIL single_wait_quiet got %0d bad cycles want 0", quiet_bad); end
        end
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_on_finish got %0h want 0", rsp_valid); end
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0h want 1", rsp_valid); end
        n_vec++; if ({rsp_id, rsp_err} !== 3'b000) begin n_err++; $display("FAIL single_id_err got %b want 000", {rsp_id, rsp_err}); end
        n_vec++; if ({rsp_x, rsp_y, rsp_z} !== {14'h0400, 14'h0100, 14'h0000}) begin n_err++; $display("FAIL single_result got %h want %h", {rsp_x, rsp_y, rsp_z}, {14'h0400, 14'h0100, 14'h0000}); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_vec++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_done got %b want 00", {rsp_valid, busy}); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] xv [NREQ];
        rst = 1'b1; step(); rst = 1'b0; step();
        for (int k = 0; k < NREQ; k++) begin
            xv[k] = W'(32'h100 * (k + 1) + k);
            set_req(k, 4'd1, xv[k], 14'h0011, 14'h0022);
        end
        req_valid = 4'hF; rsp_ready = 1'b1; #1;
        for (int g = 0; g < 5; g++) begin
            int exp_k = g % NREQ;
            logic [NREQ-1:0] exp_g = NREQ'(1) << exp_k;
            int stable_bad = 0;
            logic got_rsp = 1'b0;
            for (int t = 0; t < 10; t++) begin
                if (req_ready !== '0) break;
                step();
            end
            n_vec++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant%0d got %b want %b", g, req_ready, exp_g); end
            step();
            for (int t = 0; t < 20; t++) begin
                if (rsp_valid === 1'b1) begin got_rsp = 1'b1; break; end
                if (cdc_x !== xv[exp_k]) stable_bad++;
                step();
            end
            n_vec++; if (stable_bad != 0) begin n_err++; $display("FAIL rr_cdc_x_stable%0d got %0d bad cycles want 0", g, stable_bad); end
            n_vec++; if (!got_rsp || rsp_id !== 2'(exp_k)) begin n_err++; $display("FAIL rr_rsp_id%0d got valid=%0h id=%0d want valid=1 id=%0d", g, got_rsp, rsp_id, exp_k); end
            step();
        end
        req_valid = '0; rsp_ready = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        set_req(2, 4'd3, 14'h0123, 14'h0045, 14'h0067);
        req_valid = 4'b0100; #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL illegal_ready got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        n_vec++; if (cdc_start !== 1'b0) begin n_err++; $display("FAIL illegal_no_start got %0h want 0", cdc_start); end
        n_vec++; if ({rsp_valid, rsp_id, rsp_err} !== 4'b1101) begin n_err++; $display("FAIL illegal_rsp got %b want 1101", {rsp_valid, rsp_id, rsp_err}); end
        n_vec++; if ({rsp_x, rsp_y, rsp_z} !== '0) begin n_err++; $display("FAIL illegal_result got %h want 0", {rsp_x, rsp_y, rsp_z}); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL illegal_idle got %0h want 0", busy); end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic got = 1'b0;
        stub_en = 1'b0;
        set_req(1, 4'd0, 14'h00AA, 14'h00BB, 14'h00CC);
        req_valid = 4'b0010; #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL timeout_ready got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        n_vec++; if (cdc_start !== 1'b1) begin n_err++; $display("FAIL timeout_start got %0h want 1", cdc_start); end
        for (int t = 0; t < 200; t++) begin
            step(); n++;
            if (rsp_valid === 1'b1) begin got = 1'b1; break; end
        end
        n_vec++; if (!got || n != TIMEOUT + 1) begin n_err++; $display("FAIL timeout_latency got %0d want %0d", n, TIMEOUT + 1); end
        n_vec++; if ({rsp_id, rsp_err} !== 3'b011) begin n_err++; $display("FAIL timeout_id_err got %b want 011", {rsp_id, rsp_err}); end
        n_vec++; if ({rsp_x, rsp_y, rsp_z} !== '0) begin n_err++; $display("FAIL timeout_result got %h want 0", {rsp_x, rsp_y, rsp_z}); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        stub_en = 1'b1;
        cdc_x_out = 14'h02AA;
        set_req(3, 4'd2, 14'h0050, 14'h0060, 14'h0070);
        req_valid = 4'b1000; #1;
        n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL after_timeout_ready got %b want 1000", req_ready); end
        step();
        req_valid = '0;
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid === 1'b1) break;
            step();
        end
        n_vec++; if ({rsp_valid, rsp_id, rsp_err, rsp_x} !== {1'b1, 2'd3, 1'b0, 14'h02AA}) begin n_err++; $display("FAIL after_timeout_rsp got %h want %h", {rsp_valid, rsp_id, rsp_err, rsp_x}, {1'b1, 2'd3, 1'b0, 14'h02AA}); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure_and_reset();
        logic [3*W-1:0] exp_r = {14'h1ABC, 14'h0DEF, 14'h3001};
        int bad = 0;
        cdc_x_out = 14'h1ABC; cdc_y_out = 14'h0DEF; cdc_z_out = 14'h3001;
        set_req(0, 4'd0, 14'h0011, 14'h0022, 14'h0033);
        set_req(1, 4'd1, 14'h03FF, 14'h0001, 14'h0002);
        req_valid = 4'b0001; #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_ready got %b want 0001", req_ready); end
        step();
        req_valid = 4'b0010;
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid === 1'b1) break;
            step();
        end
        n_vec++; if ({rsp_valid, rsp_x, rsp_y, rsp_z} !== {1'b1, exp_r}) begin n_err++; $display("FAIL bp_first got %h want %h", {rsp_valid, rsp_x, rsp_y, rsp_z}, {1'b1, exp_r}); end
        for (int i = 1; i < 10; i++) begin
            step();
            if (rsp_valid !== 1'b1 || {rsp_x, rsp_y, rsp_z} !== exp_r || rsp_id !== 2'd0 || req_ready !== '0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_stable got %0d bad cycles want 0", bad); end
        step();
        rsp_ready = 1'b1; #1;
        n_vec++; if ({rsp_valid, req_ready} !== 5'b10000) begin n_err++; $display("FAIL bp_handshake got %b want 10000", {rsp_valid, req_ready}); end
        step();
        rsp_ready = 1'b0;
        n_vec++; if ({rsp_valid, req_ready} !== 5'b00010) begin n_err++; $display("FAIL bp_next_grant got %b want 00010", {rsp_valid, req_ready}); end
        step();
        req_valid = '0;
        step(); step();
        n_vec++; if ({busy, cdc_x} !== {1'b1, 14'h03FF}) begin n_err++; $display("FAIL rst_pre_wait got %h want %h", {busy, cdc_x}, {1'b1, 14'h03FF}); end
        rst = 1'b1; #1;
        n_vec++; if ({busy, cdc_start, rsp_valid, req_ready} !== '0) begin n_err++; $display("FAIL rst_async_ctrl got %b want 0", {busy, cdc_start, rsp_valid, req_ready}); end
        n_vec++; if ({cdc_mode, cdc_x, cdc_y, cdc_z, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z} !== '0) begin n_err++; $display("FAIL rst_async_data got %h want 0", {cdc_mode, cdc_x, cdc_y, cdc_z, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z}); end
        step(); step();
        rst = 1'b0;
        step();
        fin_force = 1'b1;
        step();
        fin_force = 1'b0;
        n_vec++; if ({busy, rsp_valid, rsp_x} !== '0) begin n_err++; $display("FAIL rst_stale_finish got %h want 0", {busy, rsp_valid, rsp_x}); end
        set_req(3, 4'd1, 14'h0333, 14'h0000, 14'h0000);
        req_valid = 4'b1011; #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n_vec++; if ({cdc_start, cdc_x} !== {1'b1, 14'h0011}) begin n_err++; $display("FAIL rst_reissue got %h want %h", {cdc_start, cdc_x}, {1'b1, 14'h0011}); end
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid === 1'b1) break;
            step();
        end
        n_vec++; if ({rsp_valid, rsp_id, rsp_err, rsp_x} !== {1'b1, 2'd0, 1'b0, 14'h1ABC}) begin n_err++; $display("FAIL rst_after_rsp got %h want %h", {rsp_valid, rsp_id, rsp_err, rsp_x}, {1'b1, 2'd0, 1'b0, 14'h1ABC}); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_backpressure_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "bench time limit expired");
    end

endmodule
